sdpram_bist_ctrl: RTL and testbench

Parametrised, synthesisable built-in self-test engine for the team's simple dual-port SRAM macros (DCACHE_SRAMx class). It writes a selected pattern to every address, then reads back and compares against a regenerated expected stream. It aligns the expected stream to the macro's read latency and reports a saturating error count and pass/done status. It sits beside each cache SRAM and drives its wr/rd ports through a test mux.

---
 rtl/sdpram_bist_pkg.sv | 28 ++
 rtl/sdpram_bist_if.sv | 37 +++
 rtl/sdpram_bist_patgen.sv | 45 ++++
 rtl/sdpram_bist_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_sdpram_bist_ctrl.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sdpram_bist_pkg.sv
// Shared types and constants for the SDPRAM BIST engine.
// Holds FSM states, pattern encodings and checkerboard words.
package sdpram_bist_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        GAP,
        READ,
        DRAIN,
        DONE
    } state_t;

    localparam logic [1:0] PAT_DOWN  = 2'b00;
    localparam logic [1:0] PAT_ADDR  = 2'b01;
    localparam logic [1:0] PAT_CHECK = 2'b10;
    localparam logic [1:0] PAT_NADDR = 2'b11;

    // Wide replicated-nibble words; users slice DATA_WIDTH bits.
    localparam int CHK_MAX_W = 256;

    localparam logic [CHK_MAX_W-1:0] CHECKER_EVEN =
        {(CHK_MAX_W / 4){4'hA}};

    localparam logic [CHK_MAX_W-1:0] CHECKER_ODD =
        {(CHK_MAX_W / 4){4'h5}};

endpackage

// File: rtl/sdpram_bist_if.sv
// BIST-to-SRAM port bundle: write port plus read port.
// master = BIST engine side, slave = SRAM / test mux side.
interface sdpram_bist_if #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 32,
    parameter int BE_WIDTH   = 4
) ();

    logic                  mem_wr_en;
    logic [ADDR_WIDTH-1:0] mem_wr_addr;
    logic [DATA_WIDTH-1:0] mem_wr_data;
    logic [BE_WIDTH-1:0]   mem_wr_byte_en;
    logic                  mem_rd_en;
    logic [ADDR_WIDTH-1:0] mem_rd_addr;
    logic [DATA_WIDTH-1:0] mem_rd_data;

    modport master (
        output mem_wr_en,
        output mem_wr_addr,
        output mem_wr_data,
        output mem_wr_byte_en,
        output mem_rd_en,
        output mem_rd_addr,
        input  mem_rd_data
    );

    modport slave (
        input  mem_wr_en,
        input  mem_wr_addr,
        input  mem_wr_data,
        input  mem_wr_byte_en,
        input  mem_rd_en,
        input  mem_rd_addr,
        output mem_rd_data
    );

endinterface

// File: rtl/sdpram_bist_patgen.sv
// Test pattern generator; one copy makes write data, one expected data.
// Only the down-count pattern has state; the rest derive from addr.
module sdpram_bist_patgen
    import sdpram_bist_pkg::*;
#(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  advance,
    input  logic [1:0]            pattern_sel,
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] data
);

    // Number of words emitted since clear; down-count data is its inverse.
    logic [DATA_WIDTH-1:0] dec;

    // Step count: reset/clear to zero, +1 per advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dec <= '0;
        end else if (clear) begin
            dec <= '0;
        end else if (advance) begin
            dec <= dec + 1'b1;
        end
    end

    // Select the word for the current address and pattern.
    always_comb begin
        data = '0;
        unique case (pattern_sel)
            PAT_DOWN:  data = ~dec;
            PAT_ADDR:  data = DATA_WIDTH'(addr);
            PAT_CHECK: data = addr[0] ? CHECKER_ODD[DATA_WIDTH-1:0]
                                      : CHECKER_EVEN[DATA_WIDTH-1:0];
            PAT_NADDR: data = ~DATA_WIDTH'(addr);
            default:   data = '0;
        endcase
    end

endmodule

// File: rtl/sdpram_bist_ctrl.sv
// BIST engine for simple dual-port SRAM macros: write, gap, read-compare.
// Optional first-error log enabled by defining SDPRAM_BIST_ERR_LOG_EN.
module sdpram_bist_ctrl
    import sdpram_bist_pkg::*;
#(
    parameter int ADDR_WIDTH    = 9,
    parameter int DATA_WIDTH    = 32,
    parameter int BE_WIDTH      = 4,
    parameter int BYTE_SIZE     = 8,
    parameter int RD_LATENCY    = 1,
    parameter int ERR_CNT_WIDTH = 3
) (
    input  logic                     wr_clk,
    input  logic                     tb_wr_rst,
    input  logic                     start,
    input  logic [1:0]               pattern_sel,
    output logic                     busy,
    output logic                     done,
    output logic                     pass,
    output logic [ERR_CNT_WIDTH-1:0] err_cnt,
`ifdef SDPRAM_BIST_ERR_LOG_EN
    output logic [ADDR_WIDTH-1:0]    first_err_addr,
    output logic [DATA_WIDTH-1:0]    first_err_exp,
    output logic [DATA_WIDTH-1:0]    first_err_got,
    output logic                     first_err_vld,
`endif
    sdpram_bist_if.master            mem
);

    if (DATA_WIDTH != BE_WIDTH * BYTE_SIZE) begin : g_bad_width
        $error("DATA_WIDTH must equal BE_WIDTH*BYTE_SIZE");
    end

    // Drain ends RD_LATENCY-1 counts past the terminal read count.
    localparam logic [ADDR_WIDTH:0] DRAIN_END =
        (ADDR_WIDTH + 1)'(2 ** ADDR_WIDTH + RD_LATENCY - 1);

    state_t                  state;
    state_t                  state_nxt;
    logic [ADDR_WIDTH:0]     cnt;
    logic [ADDR_WIDTH:0]     cnt_inc;
    logic [1:0]              psel;
    logic                    accept;
    logic                    wr_act;
    logic                    rd_act;
    logic [DATA_WIDTH-1:0]   wr_pat;
    logic [DATA_WIDTH-1:0]   exp_pat;
    logic [DATA_WIDTH-1:0]   exp_pipe [RD_LATENCY];
    logic [RD_LATENCY-1:0]   vld_pipe;
    logic                    miss;

    assign accept  = start && (state == IDLE || state == DONE);
    assign wr_act  = (state == WRITE);
    assign rd_act  = (state == READ);
    assign cnt_inc = cnt + 1'b1;
    assign miss    = vld_pipe[RD_LATENCY-1] &&
                     (mem.mem_rd_data != exp_pipe[RD_LATENCY-1]);

    // State register.
    always_ff @(posedge wr_clk or posedge tb_wr_rst) begin
        if (tb_wr_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; the carry into cnt's top bit marks the last address.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE, DONE: if (start) state_nxt = WRITE;
            WRITE:      if (cnt_inc[ADDR_WIDTH]) state_nxt = GAP;
            GAP:        state_nxt = READ;
            READ:       if (cnt_inc[ADDR_WIDTH]) state_nxt = DRAIN;
            DRAIN:      if (cnt == DRAIN_END) state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
    end

    // Output decode: SRAM port drive and status flags.
    always_comb begin
        mem.mem_wr_en      = 1'b0;
        mem.mem_wr_addr    = '0;
        mem.mem_wr_data    = '0;
        mem.mem_wr_byte_en = '0;
        mem.mem_rd_en      = 1'b0;
        mem.mem_rd_addr    = '0;
        unique case (1'b1)
            wr_act: begin
                mem.mem_wr_en      = 1'b1;
                mem.mem_wr_addr    = cnt[ADDR_WIDTH-1:0];
                mem.mem_wr_data    = wr_pat;
                mem.mem_wr_byte_en = '1;
            end
            rd_act: begin
                mem.mem_rd_en      = 1'b1;
                mem.mem_rd_addr    = cnt[ADDR_WIDTH-1:0];
            end
            default: ;
        endcase
        busy = (state == WRITE) || (state == GAP) ||
               (state == READ)  || (state == DRAIN);
        done = (state == DONE);
        pass = done && (err_cnt == '0);
    end

    // Address counter: counts through WRITE/READ/DRAIN, zero elsewhere.
    always_ff @(posedge wr_clk or posedge tb_wr_rst) begin
        if (tb_wr_rst) begin
            cnt <= '0;
        end else begin
            unique case (state)
                WRITE, READ, DRAIN: cnt <= cnt_inc;
                default:            cnt <= '0;
            endcase
        end
    end

    // Pattern select is latched on an accepted start for the whole run.
    always_ff @(posedge wr_clk or posedge tb_wr_rst) begin
        if (tb_wr_rst) begin
            psel <= '0;
        end else if (accept) begin
            psel <= pattern_sel;
        end
    end

    sdpram_bist_patgen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_wr_gen (
        .clk         (wr_clk),
        .rst         (tb_wr_rst),
        .clear       (accept),
        .advance     (wr_act),
        .pattern_sel (psel),
        .addr        (cnt[ADDR_WIDTH-1:0]),
        .data        (wr_pat)
    );

    sdpram_bist_patgen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_exp_gen (
        .clk         (wr_clk),
        .rst         (tb_wr_rst),
        .clear       (state == GAP),
        .advance     (rd_act),
        .pattern_sel (psel),
        .addr        (cnt[ADDR_WIDTH-1:0]),
        .data        (exp_pat)
    );

    // Expected-data pipeline aligned to the macro read latency.
    always_ff @(posedge wr_clk or posedge tb_wr_rst) begin
        if (tb_wr_rst) begin
            vld_pipe <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                exp_pipe[i] <= '0;
            end
        end else begin
            vld_pipe[0] <= rd_act;
            exp_pipe[0] <= exp_pat;
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                exp_pipe[i] <= exp_pipe[i-1];
            end
        end
    end

    // Saturating miscompare counter, cleared on an accepted start.
    always_ff @(posedge wr_clk or posedge tb_wr_rst) begin
        if (tb_wr_rst) begin
            err_cnt <= '0;
        end else if (accept) begin
            err_cnt <= '0;
        end else if (miss && (err_cnt != '1)) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end

`ifdef SDPRAM_BIST_ERR_LOG_EN
    logic [ADDR_WIDTH-1:0] addr_pipe [RD_LATENCY];

    // Read address rides alongside the expected data.
    always_ff @(posedge wr_clk or posedge tb_wr_rst) begin
        if (tb_wr_rst) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                addr_pipe[i] <= '0;
            end
        end else begin
            addr_pipe[0] <= cnt[ADDR_WIDTH-1:0];
            for (int i = 1; i < RD_LATENCY; i++) begin
                addr_pipe[i] <= addr_pipe[i-1];
            end
        end
    end

    // Capture the first miscompare of a run and hold it.
    always_ff @(posedge wr_clk or posedge tb_wr_rst) begin
        if (tb_wr_rst) begin
            first_err_addr <= '0;
            first_err_exp  <= '0;
            first_err_got  <= '0;
            first_err_vld  <= 1'b0;
        end else if (accept) begin
            first_err_addr <= '0;
            first_err_exp  <= '0;
            first_err_got  <= '0;
            first_err_vld  <= 1'b0;
        end else if (miss && !first_err_vld) begin
            first_err_addr <= addr_pipe[RD_LATENCY-1];
            first_err_exp  <= exp_pipe[RD_LATENCY-1];
            first_err_got  <= mem.mem_rd_data;
            first_err_vld  <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_sdpram_bist_ctrl.sv
// Directed bench for sdpram_bist_ctrl with 1- and 2-cycle SRAM models.
// Covers patterns, fault counting, saturation, restart and reset abort.
module tb_sdpram_bist_ctrl;
    import sdpram_bist_pkg::*;

    localparam int AW = 9;
    localparam int DW = 32;
    localparam int N  = 512;

    logic          wr_clk    = 1'b0;
    logic          tb_wr_rst = 1'b0;
    logic          start1    = 1'b0;
    logic          start2    = 1'b0;
    logic [1:0]    ps1       = 2'b00;
    logic [1:0]    ps2       = 2'b00;
    logic          busy1, done1, pass1;
    logic          busy2, done2, pass2;
    logic [2:0]    err1, err2;

    int errors = 0;
    int checks = 0;

    always #5 wr_clk = ~wr_clk;

    sdpram_bist_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(4)) m1 ();
    sdpram_bist_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(4)) m2 ();

`ifdef SDPRAM_BIST_ERR_LOG_EN
    logic [AW-1:0] fa1, fa2;
    logic [DW-1:0] fe1, fg1, fe2, fg2;
    logic          fv1, fv2;
`endif

    sdpram_bist_ctrl #(.RD_LATENCY(1)) dut1 (
        .wr_clk         (wr_clk),
        .tb_wr_rst      (tb_wr_rst),
        .start          (start1),
        .pattern_sel    (ps1),
        .busy           (busy1),
        .done           (done1),
        .pass           (pass1),
        .err_cnt        (err1),
`ifdef SDPRAM_BIST_ERR_LOG_EN
        .first_err_addr (fa1),
        .first_err_exp  (fe1),
        .first_err_got  (fg1),
        .first_err_vld  (fv1),
`endif
        .mem            (m1)
    );

    sdpram_bist_ctrl #(.RD_LATENCY(2)) dut2 (
        .wr_clk         (wr_clk),
        .tb_wr_rst      (tb_wr_rst),
        .start          (start2),
        .pattern_sel    (ps2),
        .busy           (busy2),
        .done           (done2),
        .pass           (pass2),
        .err_cnt        (err2),
`ifdef SDPRAM_BIST_ERR_LOG_EN
        .first_err_addr (fa2),
        .first_err_exp  (fe2),
        .first_err_got  (fg2),
        .first_err_vld  (fv2),
`endif
        .mem            (m2)
    );

    logic [DW-1:0] ram1 [N];
    logic [DW-1:0] ram2 [N];
    logic [DW-1:0] cap1 [N];
    logic [DW-1:0] cap2 [N];
    logic [DW-1:0] rq2;
    logic          stuck1 = 1'b0;
    logic          stuck0 = 1'b0;
    logic          be_bad = 1'b0;
    int            wtot1  = 0;

    function automatic logic [DW-1:0] flt(input logic [DW-1:0] d,
                                          input logic [AW-1:0] a);
        logic [DW-1:0] r;
        r = d;
        if (stuck0) r = '0;
        if (stuck1 && (a == 4 || a == 10 || a == 20)) r[0] = 1'b1;
        return r;
    endfunction

    // Unregistered-output macro with optional fault injection.
    always @(posedge wr_clk) begin
        if (m1.mem_wr_en) begin
            ram1[m1.mem_wr_addr] <= m1.mem_wr_data;
            cap1[m1.mem_wr_addr] <= m1.mem_wr_data;
            wtot1 <= wtot1 + 1;
            if (m1.mem_wr_byte_en != 4'hF) be_bad <= 1'b1;
        end
        if (m1.mem_rd_en)
            m1.mem_rd_data <= flt(ram1[m1.mem_rd_addr], m1.mem_rd_addr);
    end

    // Registered-output macro.
    always @(posedge wr_clk) begin
        if (m2.mem_wr_en) begin
            ram2[m2.mem_wr_addr] <= m2.mem_wr_data;
            cap2[m2.mem_wr_addr] <= m2.mem_wr_data;
        end
        if (m2.mem_rd_en) rq2 <= ram2[m2.mem_rd_addr];
        m2.mem_rd_data <= rq2;
    end

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pulse start on one DUT, optionally re-pulse at cycle 'extra',
    // and return cycles from WRITE entry until done.
    task automatic run(input bit sel, input logic [1:0] ps,
                       input int extra, output int cyc);
        if (sel) begin
            ps2 = ps; start2 = 1'b1;
        end else begin
            ps1 = ps; start1 = 1'b1;
        end
        @(negedge wr_clk);
        start1 = 1'b0;
        start2 = 1'b0;
        ps1 = ~ps;
        ps2 = ~ps;
        chk("accept_busy", sel ? busy2 : busy1, 1);
        chk("accept_done", sel ? done2 : done1, 0);
        chk("accept_err", sel ? err2 : err1, 0);
        cyc = 0;
        while (!(sel ? done2 : done1) && cyc < 3000) begin
            start1 = (!sel && extra != 0 && cyc == extra);
            @(negedge wr_clk);
            cyc++;
        end
        start1 = 1'b0;
        chk("run_done", sel ? done2 : done1, 1);
    endtask

    int cyc;
    int w0;

    initial begin
        #1 tb_wr_rst = 1'b1;
        #1;
        chk("rst_busy", busy1, 0);
        chk("rst_done", done1, 0);
        chk("rst_pass", pass1, 0);
        chk("rst_err", err1, 0);
        chk("rst_wr_en", m1.mem_wr_en, 0);
        chk("rst_rd_en", m1.mem_rd_en, 0);
        repeat (2) @(negedge wr_clk);
        tb_wr_rst = 1'b0;
        @(negedge wr_clk);

        // Down-count pattern, 1-cycle macro.
        w0 = wtot1;
        run(0, 2'b00, 0, cyc);
        chk("t1_cycles", cyc, 1026);
        chk("t1_pass", pass1, 1);
        chk("t1_err", err1, 0);
        chk("t1_wd0", cap1[0], 32'hFFFF_FFFF);
        chk("t1_wd1", cap1[1], 32'hFFFF_FFFE);
        chk("t1_wd511", cap1[511], 32'hFFFF_FE00);
        chk("t1_writes", wtot1 - w0, N);
        chk("t1_be", be_bad, 0);

        // Stuck-at-1 on bit 0 at three even addresses, data = address.
        stuck1 = 1'b1;
        run(0, 2'b01, 0, cyc);
        chk("t3_cycles", cyc, 1026);
        chk("t3_err", err1, 3);
        chk("t3_pass", pass1, 0);
        chk("t3_wd9", cap1[9], 32'h0000_0009);
`ifdef SDPRAM_BIST_ERR_LOG_EN
        chk("t3_fvld", fv1, 1);
        chk("t3_faddr", fa1, 4);
        chk("t3_fexp", fe1, 32'h4);
        chk("t3_fgot", fg1, 32'h5);
`endif
        stuck1 = 1'b0;

        // Everything reads zero, ~address pattern: counter saturates.
        stuck0 = 1'b1;
        run(0, 2'b11, 0, cyc);
        chk("t4_err_sat", err1, 7);
        chk("t4_pass", pass1, 0);
        chk("t4_wd5", cap1[5], 32'hFFFF_FFFA);

        // Restart from a failing DONE with the fault removed.
        stuck0 = 1'b0;
        run(0, 2'b00, 0, cyc);
        chk("t6_cycles", cyc, 1026);
        chk("t6_err", err1, 0);
        chk("t6_pass", pass1, 1);

        // Checkerboard on the registered-output macro.
        run(1, 2'b10, 0, cyc);
        chk("t2_cycles", cyc, 1027);
        chk("t2_pass", pass2, 1);
        chk("t2_wd0", cap2[0], 32'hAAAA_AAAA);
        chk("t2_wd1", cap2[1], 32'h5555_5555);

        // Start pulse during WRITE must not restart or stretch the run.
        run(0, 2'b01, 100, cyc);
        chk("t5_cycles", cyc, 1026);
        chk("t5_pass", pass1, 1);

        // Reset during READ aborts to IDLE immediately.
        ps1 = 2'b00;
        start1 = 1'b1;
        @(negedge wr_clk);
        start1 = 1'b0;
        repeat (700) @(negedge wr_clk);
        chk("t5_in_read", m1.mem_rd_en, 1);
        tb_wr_rst = 1'b1;
        #1;
        chk("t5_state", 64'(dut1.state), 64'(IDLE));
        chk("t5_busy", busy1, 0);
        chk("t5_done", done1, 0);
        chk("t5_pass0", pass1, 0);
        chk("t5_err0", err1, 0);
        chk("t5_rd_en", m1.mem_rd_en, 0);
        chk("t5_rd_addr", m1.mem_rd_addr, 0);
        chk("t5_wr_en", m1.mem_wr_en, 0);
        chk("t5_wr_addr", m1.mem_wr_addr, 0);
        chk("t5_wr_data", m1.mem_wr_data, 0);
        chk("t5_wr_be", m1.mem_wr_byte_en, 0);
`ifdef SDPRAM_BIST_ERR_LOG_EN
        chk("t5_fvld", fv1, 0);
`endif
        repeat (2) @(negedge wr_clk);
        tb_wr_rst = 1'b0;
        repeat (3) @(negedge wr_clk);
        chk("t5_idle_busy", busy1, 0);
        chk("t5_idle_done", done1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
